jtag_instruction_unit: RTL

Parametrised JTAG instruction register plus registered instruction decoder. Sits between the TAP controller and the data-register mux: it captures, shifts and updates the IR, decodes the active instruction into a one-hot data-register select, drives the BSR mode, and optionally rejects truncated IR scans. It replaces the separate IR and combinational decoder pair and adds IR-width and DR-count generality, status capture, a change strobe and length checking.

---
 rtl/jtag_types_pkg.sv | 44 ++++
 rtl/jtag_ir_shifter.sv | 39 +++
 rtl/jtag_instruction_unit.sv | 78 +++++++
 3 files changed

// File: rtl/jtag_types_pkg.sv
// jtag_types_pkg: shared JTAG opcodes, data-register indices and the instruction decoder.
package jtag_types_pkg;

    parameter int IR_WIDTH_DEF = 5;

    localparam logic [31:0] OP_EXTEST         = 32'h00;
    localparam logic [31:0] OP_IDCODE         = 32'h01;
    localparam logic [31:0] OP_SAMPLE_PRELOAD = 32'h02;
    localparam logic [31:0] OP_AHB            = 32'h10;
    localparam logic [31:0] OP_TMP_STATUS     = 32'h11;
    localparam logic [IR_WIDTH_DEF-1:0] OP_BYPASS = '1;

    localparam logic [2:0] DR_BSR    = 3'd0;
    localparam logic [2:0] DR_ID     = 3'd1;
    localparam logic [2:0] DR_BYPASS = 3'd2;
    localparam logic [2:0] DR_AHB    = 3'd3;
    localparam logic [2:0] DR_TMP    = 3'd4;

    typedef logic [IR_WIDTH_DEF-1:0] instruction_t;

    typedef struct packed {
        logic [4:0] dr_select;
        logic       bsr_mode;
        logic       instr_valid;
    } decode_t;

    // BYPASS is all ones at the actual IR width, so the width is passed in.
    function automatic decode_t decode(input logic [31:0] instr, input int w);
        decode_t    d;
        logic [2:0] idx;
        logic       bypass;
        bypass = instr == 32'((33'd1 << w) - 33'd1);
        idx = (instr == OP_EXTEST || instr == OP_SAMPLE_PRELOAD) ? DR_BSR :
              (instr == OP_IDCODE)     ? DR_ID  :
              (instr == OP_AHB)        ? DR_AHB :
              (instr == OP_TMP_STATUS) ? DR_TMP : DR_BYPASS;
        d.dr_select   = 5'd1 << idx;
        d.bsr_mode    = instr == OP_EXTEST;
        d.instr_valid = bypass || instr == OP_EXTEST || instr == OP_IDCODE ||
                        instr == OP_SAMPLE_PRELOAD || instr == OP_AHB || instr == OP_TMP_STATUS;
        return d;
    endfunction

endpackage

// File: rtl/jtag_ir_shifter.sv
// jtag_ir_shifter: IR capture/shift register with a saturating shift counter.
module jtag_ir_shifter
    import jtag_types_pkg::*;
#(
    parameter int IR_WIDTH = 5,
    parameter int CW       = $clog2(IR_WIDTH + 1)
) (
    input  logic                TCK,
    input  logic                TRST,
    input  logic                tlr,
    input  logic                capture_ir,
    input  logic                shift_ir,
    input  logic                update_ir,
    input  logic                tdi,
    input  logic [IR_WIDTH-3:0] ir_status,
    output logic [IR_WIDTH-1:0] shift_reg,
    output logic [CW-1:0]       shift_cnt,
    output logic                ir_tdo
);

    assign ir_tdo = shift_reg[0];

    // update_ir outranks capture/shift, so the register simply holds during it.
    always_ff @(posedge TCK or posedge TRST) begin
        if (TRST || tlr) begin
            shift_reg <= IR_WIDTH'(OP_IDCODE);
            shift_cnt <= '0;
        end else if (update_ir) begin
            shift_reg <= shift_reg;
        end else if (capture_ir) begin
            shift_reg <= {ir_status, 2'b01};
            shift_cnt <= '0;
        end else if (shift_ir) begin
            shift_reg <= {tdi, shift_reg[IR_WIDTH-1:1]};
            shift_cnt <= (shift_cnt == CW'(IR_WIDTH)) ? shift_cnt : shift_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/jtag_instruction_unit.sv
// jtag_instruction_unit: JTAG instruction register with registered one-hot DR decode,
// change strobe and optional rejection of truncated IR scans.
module jtag_instruction_unit
    import jtag_types_pkg::*;
#(
    parameter int IR_WIDTH   = 5,
    parameter int NUM_DR     = 5,
    parameter bit STRICT_LEN = 1
) (
    input  logic                TCK,
    input  logic                TRST,
    input  logic                tlr,
    input  logic                capture_ir,
    input  logic                shift_ir,
    input  logic                update_ir,
    input  logic                tdi,
    input  logic [IR_WIDTH-3:0] ir_status,
    output logic                ir_tdo,
    output logic [IR_WIDTH-1:0] instruction,
    output logic [NUM_DR-1:0]   dr_select,
    output logic                bsr_mode,
    output logic                instr_valid,
    output logic                instr_changed,
    output logic                ir_error
);

    localparam int CW = $clog2(IR_WIDTH + 1);
    localparam decode_t ID_DEC = decode(OP_IDCODE, IR_WIDTH);

    logic [IR_WIDTH-1:0] shift_reg;
    logic [CW-1:0]       shift_cnt;
    logic [IR_WIDTH-1:0] next_instr;
    logic                short_scan;
    logic                load;
    decode_t             next_dec;

    jtag_ir_shifter #(.IR_WIDTH(IR_WIDTH), .CW(CW)) u_shifter (
        .TCK        (TCK),
        .TRST       (TRST),
        .tlr        (tlr),
        .capture_ir (capture_ir),
        .shift_ir   (shift_ir),
        .update_ir  (update_ir),
        .tdi        (tdi),
        .ir_status  (ir_status),
        .shift_reg  (shift_reg),
        .shift_cnt  (shift_cnt),
        .ir_tdo     (ir_tdo)
    );

    always_comb begin
        short_scan = STRICT_LEN && (shift_cnt < CW'(IR_WIDTH));
        load       = tlr || (update_ir && !short_scan);
        next_instr = tlr ? IR_WIDTH'(OP_IDCODE) : shift_reg;
        next_dec   = decode(32'(next_instr), IR_WIDTH);
    end

    always_ff @(posedge TCK or posedge TRST) begin
        if (TRST) begin
            instruction   <= IR_WIDTH'(OP_IDCODE);
            dr_select     <= NUM_DR'(ID_DEC.dr_select);
            bsr_mode      <= ID_DEC.bsr_mode;
            instr_valid   <= ID_DEC.instr_valid;
            instr_changed <= 1'b0;
            ir_error      <= 1'b0;
        end else begin
            instr_changed <= load && (next_instr != instruction);
            ir_error      <= !tlr && update_ir && short_scan;
            if (load) begin
                instruction <= next_instr;
                dr_select   <= NUM_DR'(next_dec.dr_select);
                bsr_mode    <= next_dec.bsr_mode;
                instr_valid <= next_dec.instr_valid;
            end
        end
    end

endmodule
